// File: rtl/l2_coalescing_write_buffer_pkg.sv
// Shared defaults and drain-state encoding for the L2 coalescing write buffer.
package l2_coalescing_write_buffer_pkg;
    localparam int WB_L2_DEPTH        = 8;
    localparam int WB_L2_LINE_WORDS   = 4;
    localparam int WB_L2_DRAIN_THRESH = 4;

    typedef enum logic {WB_IDLE, WB_DRAIN} wb_l2_state_e;
endpackage

// File: rtl/l2_coalescing_write_buffer_tag_match.sv
// Parallel tag compare: store-merge one-hot plus youngest matching entry for the L2 miss probe.
module l2_wb_tag_match
    import l2_coalescing_write_buffer_pkg::*;
#(
    parameter int TAG_W = 26,
    parameter int DEPTH = WB_L2_DEPTH,
    localparam int IW = $clog2(DEPTH),
    localparam int PW = IW + 1
) (
    input  logic [DEPTH-1:0][TAG_W-1:0] tags,
    input  logic [DEPTH-1:0]            valid,
    input  logic [DEPTH-1:0]            lock,
    input  logic [PW-1:0]               head,
    input  logic [PW-1:0]               tail,
    input  logic [TAG_W-1:0]            st_tag,
    input  logic [TAG_W-1:0]            ld_tag,
    output logic [DEPTH-1:0]            merge_oh,
    output logic                        merge_hit,
    output logic                        probe_hit,
    output logic [IW-1:0]               probe_idx
);
    logic [PW-1:0] occ;

    for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
        assign merge_oh[i] = valid[i] && !lock[i] && (tags[i] == st_tag);
    end
    assign merge_hit = |merge_oh;
    assign occ       = tail - head;

    // Walk oldest to youngest so the last match wins.
    always_comb begin
        logic [IW-1:0] idx;
        probe_hit = 1'b0;
        probe_idx = '0;
        idx       = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head[IW-1:0] + IW'(k);
            if (PW'(k) < occ && valid[idx] && tags[idx] == ld_tag) begin
                probe_hit = 1'b1;
                probe_idx = idx;
            end
        end
    end
endmodule

// File: rtl/l2_coalescing_write_buffer.sv
// Line-granular coalescing write buffer between L2 and memory; FIFO drain with store merge.
// Optional WB_L2_FORWARD_EN adds ld_data/ld_be forwarding from the youngest probe match.
module l2_coalescing_write_buffer
    import l2_coalescing_write_buffer_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int LINE_WORDS   = WB_L2_LINE_WORDS,
    parameter int TAG_W        = 26,
    parameter int DEPTH        = WB_L2_DEPTH,
    parameter int DRAIN_THRESH = WB_L2_DRAIN_THRESH,
    localparam int BPW    = DATA_W / 8,
    localparam int LINE_W = LINE_WORDS * DATA_W,
    localparam int LINE_B = LINE_WORDS * BPW,
    localparam int IW     = $clog2(DEPTH),
    localparam int PW     = IW + 1,
    localparam int WIW    = $clog2(LINE_WORDS)
) (
    input  logic              clk_l2,
    input  logic              rst_n,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [TAG_W-1:0]  st_line_addr,
    input  logic [WIW-1:0]    st_word_idx,
    input  logic [DATA_W-1:0] st_data,
    input  logic [BPW-1:0]    st_be,
    input  logic              flush,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [TAG_W-1:0]  mem_line_addr,
    output logic [LINE_W-1:0] mem_data,
    output logic [LINE_B-1:0] mem_be,
    input  logic [TAG_W-1:0]  ld_line_addr,
    output logic              ld_hit,
    output logic              ld_full_line,
`ifdef WB_L2_FORWARD_EN
    output logic [LINE_W-1:0] ld_data,
    output logic [LINE_B-1:0] ld_be,
`endif
    output logic [PW-1:0]     count,
    output logic              full,
    output logic              empty
);
    logic [DEPTH-1:0]              vld;
    logic [DEPTH-1:0][TAG_W-1:0]   tags;
    logic [DEPTH-1:0][LINE_W-1:0]  dat;
    logic [DEPTH-1:0][LINE_B-1:0]  msk;
    logic [PW-1:0]                 head, tail, cnt_nxt;
    logic [IW-1:0]                 head_idx, tail_idx, probe_idx;
    logic [DEPTH-1:0]              lock, merge_oh;
    logic                          merge_hit, probe_hit;
    logic                          accept, alloc, drain_fire, go;
    logic [LINE_B-1:0]             be_line;
    logic [LINE_W-1:0]             data_line;
    wb_l2_state_e                  state;

    assign head_idx = head[IW-1:0];
    assign tail_idx = tail[IW-1:0];
    assign count    = tail - head;
    assign empty    = (head == tail);
    assign full     = (head_idx == tail_idx) && (head[PW-1] != tail[PW-1]);
    assign lock     = (state == WB_DRAIN) ? (DEPTH'(1) << head_idx) : '0;

    l2_wb_tag_match #(.TAG_W(TAG_W), .DEPTH(DEPTH)) u_match (
        .tags(tags), .valid(vld), .lock(lock), .head(head), .tail(tail),
        .st_tag(st_line_addr), .ld_tag(ld_line_addr),
        .merge_oh(merge_oh), .merge_hit(merge_hit),
        .probe_hit(probe_hit), .probe_idx(probe_idx)
    );

    // full is registered state only, so mem_ready never reaches st_ready.
    assign st_ready   = merge_hit || !full;
    assign accept     = st_valid && st_ready;
    assign alloc      = accept && !merge_hit;
    assign drain_fire = mem_valid && mem_ready;
    assign cnt_nxt    = count + PW'(alloc) - PW'(drain_fire);
    assign go         = (cnt_nxt != '0) && ((cnt_nxt >= PW'(DRAIN_THRESH)) || flush);

    // Place the store word at its line position; unselected bytes stay zero.
    always_comb begin
        be_line   = '0;
        data_line = '0;
        for (int w = 0; w < LINE_WORDS; w++)
            for (int b = 0; b < BPW; b++)
                if (w == int'(st_word_idx) && st_be[b]) begin
                    be_line[w*BPW+b]           = 1'b1;
                    data_line[(w*BPW+b)*8 +: 8] = st_data[b*8 +: 8];
                end
    end

    always_ff @(posedge clk_l2 or negedge rst_n) begin
        if (!rst_n) begin
            vld  <= '0;
            tags <= '0;
            dat  <= '0;
            msk  <= '0;
            head <= '0;
            tail <= '0;
        end else begin
            if (drain_fire) begin
                vld[head_idx] <= 1'b0;
                head          <= head + PW'(1);
            end
            if (alloc) begin
                vld[tail_idx]  <= 1'b1;
                tags[tail_idx] <= st_line_addr;
                dat[tail_idx]  <= data_line;
                msk[tail_idx]  <= be_line;
                tail           <= tail + PW'(1);
            end
            for (int i = 0; i < DEPTH; i++)
                if (accept && merge_oh[i]) begin
                    msk[i] <= msk[i] | be_line;
                    for (int b = 0; b < LINE_B; b++)
                        if (be_line[b]) dat[i][b*8 +: 8] <= data_line[b*8 +: 8];
                end
        end
    end

    // Drain decision looks at post-edge occupancy so draining starts right after the trigger store.
    always_ff @(posedge clk_l2 or negedge rst_n) begin
        if (!rst_n) begin
            state     <= WB_IDLE;
            mem_valid <= 1'b0;
        end else begin
            case (state)
                WB_IDLE: if (go) begin
                    state     <= WB_DRAIN;
                    mem_valid <= 1'b1;
                end
                WB_DRAIN: if (mem_ready) begin
                    state     <= go ? WB_DRAIN : WB_IDLE;
                    mem_valid <= go;
                end
                default: begin
                    state     <= WB_IDLE;
                    mem_valid <= 1'b0;
                end
            endcase
        end
    end

    assign mem_line_addr = vld[head_idx] ? tags[head_idx] : '0;
    assign mem_data      = vld[head_idx] ? dat[head_idx]  : '0;
    assign mem_be        = vld[head_idx] ? msk[head_idx]  : '0;
    assign ld_hit        = probe_hit;
    assign ld_full_line  = probe_hit && (&msk[probe_idx]);
`ifdef WB_L2_FORWARD_EN
    assign ld_data       = probe_hit ? dat[probe_idx] : '0;
    assign ld_be         = probe_hit ? msk[probe_idx] : '0;
`endif

`ifndef SYNTHESIS
    a_no_alloc_full: assert property (@(posedge clk_l2) disable iff (!rst_n) !(alloc && full));
    a_no_drain_empty: assert property (@(posedge clk_l2) disable iff (!rst_n) !(drain_fire && empty));
`endif
endmodule

// File: tb/tb_l2_coalescing_write_buffer.sv
// Directed bench with a queue-based line model checked every cycle, plus literal spot checks.
module tb_l2_coalescing_write_buffer;
    localparam int DATA_W = 32, LINE_WORDS = 4, TAG_W = 26, DEPTH = 8, THRESH = 4;
    localparam int BPW = DATA_W / 8, LINE_W = LINE_WORDS * DATA_W, LINE_B = LINE_WORDS * BPW;

    logic              clk_l2, rst_n;
    logic              st_valid, st_ready, flush, mem_valid, mem_ready;
    logic [TAG_W-1:0]  st_line_addr, mem_line_addr, ld_line_addr;
    logic [1:0]        st_word_idx;
    logic [DATA_W-1:0] st_data;
    logic [BPW-1:0]    st_be;
    logic [LINE_W-1:0] mem_data;
    logic [LINE_B-1:0] mem_be;
    logic              ld_hit, ld_full_line, full, empty;
    logic [3:0]        count;
`ifdef WB_L2_FORWARD_EN
    logic [LINE_W-1:0] ld_data;
    logic [LINE_B-1:0] ld_be;
`endif

    l2_coalescing_write_buffer dut (
        .clk_l2(clk_l2), .rst_n(rst_n), .st_valid(st_valid), .st_ready(st_ready),
        .st_line_addr(st_line_addr), .st_word_idx(st_word_idx), .st_data(st_data), .st_be(st_be),
        .flush(flush), .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_line_addr(mem_line_addr),
        .mem_data(mem_data), .mem_be(mem_be), .ld_line_addr(ld_line_addr), .ld_hit(ld_hit),
        .ld_full_line(ld_full_line),
`ifdef WB_L2_FORWARD_EN
        .ld_data(ld_data), .ld_be(ld_be),
`endif
        .count(count), .full(full), .empty(empty)
    );

    initial begin
        clk_l2 = 1'b0;
        forever #5 clk_l2 = ~clk_l2;
    end

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [LINE_W-1:0] data;
        logic [LINE_B-1:0] be;
    } ent_t;

    ent_t             q[$];
    bit               draining;
    logic [TAG_W-1:0] dut_tags[$], mdl_tags[$];
    logic [LINE_B-1:0] dut_bes[$];
    int               n_cmp = 0, n_err = 0;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: ordered list of lines; head is locked while draining.
    always @(negedge clk_l2) begin : cmp
        int mj, pj, pos;
        bit rdy, acc, fire, go;
        ent_t e;
        if (!rst_n) begin
            q.delete();
            draining = 0;
        end
        mj = -1;
        pj = -1;
        for (int j = 0; j < q.size(); j++) begin
            if (q[j].tag == st_line_addr && !(draining && j == 0)) mj = j;
            if (q[j].tag == ld_line_addr) pj = j;
        end
        rdy = (mj >= 0) || (q.size() < DEPTH);
        chk("count", count, q.size());
        chk("full", full, q.size() == DEPTH);
        chk("empty", empty, q.size() == 0);
        chk("st_ready", st_ready, rdy);
        chk("mem_valid", mem_valid, draining);
        chk("mem_line_addr", mem_line_addr, q.size() > 0 ? q[0].tag : '0);
        chk("mem_data", mem_data, q.size() > 0 ? q[0].data : '0);
        chk("mem_be", mem_be, q.size() > 0 ? q[0].be : '0);
        chk("ld_hit", ld_hit, pj >= 0);
        chk("ld_full_line", ld_full_line, pj >= 0 ? (q[pj].be == '1) : 1'b0);
`ifdef WB_L2_FORWARD_EN
        chk("ld_data", ld_data, pj >= 0 ? q[pj].data : '0);
        chk("ld_be", ld_be, pj >= 0 ? q[pj].be : '0);
`endif
        if (rst_n) begin
            if (mem_valid && mem_ready) begin
                dut_tags.push_back(mem_line_addr);
                dut_bes.push_back(mem_be);
            end
            acc  = st_valid && rdy;
            fire = draining && mem_ready;
            e = '0;
            if (acc && mj >= 0) e = q[mj];
            else if (acc) e.tag = st_line_addr;
            for (int b = 0; b < BPW; b++)
                if (st_be[b]) begin
                    pos = int'(st_word_idx) * BPW + b;
                    e.be[pos] = 1'b1;
                    e.data[pos*8 +: 8] = st_data[b*8 +: 8];
                end
            if (acc && mj >= 0) q[mj] = e;
            if (fire) begin
                mdl_tags.push_back(q[0].tag);
                void'(q.pop_front());
            end
            if (acc && mj < 0) q.push_back(e);
            go = (q.size() != 0) && (q.size() >= THRESH || flush);
            if (!draining || mem_ready) draining = go;
        end
    end

    task automatic cyc();
        @(posedge clk_l2);
        #1;
    endtask

    task automatic store(input logic [TAG_W-1:0] a, input int w, input logic [31:0] d, input logic [3:0] be);
        st_line_addr = a;
        st_word_idx  = 2'(w);
        st_data      = d;
        st_be        = be;
        st_valid     = 1'b1;
        cyc();
        st_valid     = 1'b0;
    endtask

    task automatic wait_empty();
        int k = 0;
        while (!empty && k < 200) begin
            cyc();
            k++;
        end
        chk("drain_timeout", empty, 1'b1);
    endtask

    task automatic clear_logs();
        dut_tags.delete();
        dut_bes.delete();
        mdl_tags.delete();
    endtask

    initial begin
        rst_n = 1'b0; st_valid = 1'b0; st_line_addr = '0; st_word_idx = '0; st_data = '0;
        st_be = '0; flush = 1'b0; mem_ready = 1'b0; ld_line_addr = '0;
        cyc(); cyc();
        chk("rst_empty", empty, 1'b1);
        chk("rst_st_ready", st_ready, 1'b1);
        chk("rst_mem_valid", mem_valid, 1'b0);
        chk("rst_count", count, 4'd0);
        rst_n = 1'b1;
        cyc();

        // 1: word0 full, word1 low half -> mask 0x003F, no drain below threshold
        store(26'h10, 0, 32'hAABBCCDD, 4'hF);
        store(26'h10, 1, 32'h11223344, 4'h3);
        #1;
        chk("t1_count", count, 4'd1);
        chk("t1_mem_be", mem_be, 16'h003F);
        chk("t1_mem_data", mem_data, {64'h0, 32'h00003344, 32'hAABBCCDD});
        chk("t1_mem_valid", mem_valid, 1'b0);
        chk("t1_model_size", q.size(), 1);
        chk("t1_model_be", q[0].be, 16'h003F);
        flush = 1'b1; mem_ready = 1'b1;
        wait_empty();
        flush = 1'b0;
        cyc();
        clear_logs();

        // 2: threshold drain, then flush the remainder in order
        for (int i = 1; i <= 4; i++) begin
            store(26'(i), 0, 32'(i), 4'hF);
            if (i == 3) chk("t2_mv_before", mem_valid, 1'b0);
        end
        chk("t2_mv_rise", mem_valid, 1'b1);
        cyc();
        chk("t2_count_after_one", count, 4'd3);
        chk("t2_mv_drop", mem_valid, 1'b0);
        flush = 1'b1;
        wait_empty();
        flush = 1'b0;
        cyc();
        chk("t2_n_drained", dut_tags.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < dut_tags.size()) chk("t2_order", dut_tags[i], 26'(i + 1));
        chk("t2_model_n", mdl_tags.size(), 4);
        if (mdl_tags.size() == 4) chk("t2_model_last", mdl_tags[3], 26'h4);
        clear_logs();

        // 3: full buffer blocks a new line but accepts a merge
        mem_ready = 1'b0;
        for (int i = 1; i <= 8; i++) store(26'(i), 0, 32'h100 + 32'(i), 4'hF);
        #1;
        chk("t3_full", full, 1'b1);
        chk("t3_count", count, 4'd8);
        st_line_addr = 26'h99; st_word_idx = 2'd0; st_data = 32'hDEAD; st_be = 4'hF; st_valid = 1'b1;
        #1;
        chk("t3_block", st_ready, 1'b0);
        cyc();
        chk("t3_count_held", count, 4'd8);
        st_line_addr = 26'h3; st_word_idx = 2'd2; st_data = 32'hCAFEF00D;
        #1;
        chk("t3_merge_ready", st_ready, 1'b1);
        cyc();
        st_valid = 1'b0;
        ld_line_addr = 26'h3;
        #1;
        chk("t3_count_merge", count, 4'd8);
        chk("t3_probe", ld_hit, 1'b1);
        flush = 1'b1; mem_ready = 1'b1;
        wait_empty();
        cyc();
        clear_logs();

        // 4: store to locked head allocates a second entry with the same tag
        mem_ready = 1'b0;
        store(26'h5, 0, 32'h55555555, 4'hF);
        store(26'h5, 1, 32'h66666666, 4'hF);
        #1;
        chk("t4_count", count, 4'd2);
        chk("t4_mem_valid", mem_valid, 1'b1);
        chk("t4_head_data", mem_data, {96'h0, 32'h55555555});
        chk("t4_head_be", mem_be, 16'h000F);
        mem_ready = 1'b1;
        wait_empty();
        flush = 1'b0;
        cyc();
        chk("t4_n", dut_tags.size(), 2);
        if (dut_tags.size() == 2) begin
            chk("t4_tag0", dut_tags[0], 26'h5);
            chk("t4_tag1", dut_tags[1], 26'h5);
            chk("t4_be0", dut_bes[0], 16'h000F);
            chk("t4_be1", dut_bes[1], 16'h00F0);
        end
        clear_logs();

        // 5: full-line probe
        mem_ready = 1'b0;
        for (int w = 0; w < 4; w++) store(26'h7, w, 32'h70 + 32'(w), 4'hF);
        ld_line_addr = 26'h7;
        #1;
        chk("t5_count", count, 4'd1);
        chk("t5_hit", ld_hit, 1'b1);
        chk("t5_full_line", ld_full_line, 1'b1);
`ifdef WB_L2_FORWARD_EN
        chk("t5_fwd_data", ld_data, {32'h73, 32'h72, 32'h71, 32'h70});
`endif
        ld_line_addr = 26'h8;
        #1;
        chk("t5_miss", ld_hit, 1'b0);
        ld_line_addr = 26'h7;

        // 6: reset while presenting the head
        flush = 1'b1;
        cyc(); cyc();
        chk("t6_mv_before", mem_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_mem_valid", mem_valid, 1'b0);
        chk("t6_count", count, 4'd0);
        chk("t6_empty", empty, 1'b1);
        chk("t6_st_ready", st_ready, 1'b1);
        chk("t6_mem_be", mem_be, 16'h0);
        chk("t6_mem_addr", mem_line_addr, 26'h0);
        chk("t6_ld_hit", ld_hit, 1'b0);
        flush = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc(); cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
